// File: rtl/spi_multimode_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_multimode_master                                                       |
// | SPI master with CPOL/CPHA modes, bit order, runtime SCLK divider and SS.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_multimode_master #(
  parameter int word_width = 8,
  parameter int SS_width   = 1,
  parameter int div_width  = 8
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic [1:0]                                        mode,
  input  logic                                              lsb_first,
  input  logic [div_width-1:0]                              divider,
  input  logic [((SS_width > 1) ? $clog2(SS_width) : 1)-1:0] ss_index,
  input  logic [word_width-1:0]                             tx_data,
  output logic [word_width-1:0]                             rx_data,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              SCLK,
  output logic                                              MOSI,
  input  logic                                              MISO,
  output logic [SS_width-1:0]                               SS
);

  localparam int c_idx_w  = (SS_width > 1) ? $clog2(SS_width) : 1;
  localparam int c_edge_w = $clog2(2 * word_width + 1);
  localparam logic [c_edge_w-1:0] c_first_edge = c_edge_w'(1);
  localparam logic [c_edge_w-1:0] c_last_edge  = c_edge_w'(2 * word_width);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t                r_state;
  logic [div_width-1:0]  r_cnt;
  logic [div_width-1:0]  r_div;
  logic [c_edge_w-1:0]   r_edge;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_lsb;
  logic [word_width-1:0] r_tx_sh;
  logic [word_width-1:0] r_rx_sh;
  logic [word_width-1:0] r_rx_data;
  logic                  r_sclk;
  logic                  r_mosi;
  logic [SS_width-1:0]   r_ss;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_half_done;
  logic [c_edge_w-1:0]   w_edge_num;
  logic                  w_leading;
  logic                  w_sample;
  logic                  w_advance;
  logic [word_width-1:0] w_tx_next;
  logic [word_width-1:0] w_rx_next;
  logic [SS_width-1:0]   w_ss_sel;

  // Out-of-range indices match no line, so every select stays high.
  for (genvar i = 0; i < SS_width; i++) begin : g_ss_dec
    assign w_ss_sel[i] = (ss_index != c_idx_w'(i));
  end

  assign w_half_done = (r_cnt == r_div);
  assign w_edge_num  = r_edge + c_first_edge;
  assign w_leading   = w_edge_num[0];
  // CPHA=0 samples on leading edges, CPHA=1 on trailing; the other edge shifts.
  assign w_sample    = w_leading ^ r_cpha;
  assign w_advance   = !w_sample &&
                       (r_cpha ? (w_edge_num != c_first_edge) : (w_edge_num != c_last_edge));
  assign w_tx_next   = r_lsb ? {1'b0, r_tx_sh[word_width-1:1]} : {r_tx_sh[word_width-2:0], 1'b0};
  assign w_rx_next   = r_lsb ? {MISO, r_rx_sh[word_width-1:1]} : {r_rx_sh[word_width-2:0], MISO};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_div     <= '0;
      r_edge    <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss      <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sclk <= r_cpol;
          if (start) begin
            r_state <= ST_SETUP;
            r_cnt   <= '0;
            r_edge  <= '0;
            r_cpol  <= mode[1];
            r_cpha  <= mode[0];
            r_lsb   <= lsb_first;
            r_div   <= divider;
            r_tx_sh <= tx_data;
            r_rx_sh <= '0;
            r_sclk  <= mode[1];
            r_mosi  <= lsb_first ? tx_data[0] : tx_data[word_width-1];
            r_ss    <= w_ss_sel;
            r_busy  <= 1'b1;
          end
        end
        ST_SETUP, ST_SHIFT: begin
          if (w_half_done) begin
            r_cnt  <= '0;
            r_edge <= w_edge_num;
            r_sclk <= ~r_sclk;
            if (w_sample) begin
              r_rx_sh <= w_rx_next;
            end
            if (w_advance) begin
              r_tx_sh <= w_tx_next;
              r_mosi  <= r_lsb ? w_tx_next[0] : w_tx_next[word_width-1];
            end
            r_state <= (w_edge_num == c_last_edge) ? ST_HOLD : ST_SHIFT;
          end else begin
            r_cnt <= r_cnt + div_width'(1);
          end
        end
        ST_HOLD: begin
          if (w_half_done) begin
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
            r_ss      <= '1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_rx_data <= r_rx_sh;
          end else begin
            r_cnt <= r_cnt + div_width'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data = r_rx_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign SCLK    = r_sclk;
  assign MOSI    = r_mosi;
  assign SS      = r_ss;

endmodule
`default_nettype wire
